// File: rtl/stage_seq_pkg.sv
// rtl/stage_seq_pkg.sv - state encoding shared by the stage sequencer and its testbench-facing Stage port
package stage_seq_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
  } stage_e;

endpackage

// File: rtl/stage_wait_timer.sv
// rtl/stage_wait_timer.sv - consecutive-wait counter that flags the last permitted unanswered cycle
module stage_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         count,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;

  // expired marks the cycle that would be the limit-th unanswered one
  assign expired = (cnt == limit - 1'b1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - handshaked five-stage sequencer emitting register-load pulses and ROM/RAM strobes
// Optional wait timeout enabled by defining SEQ_TIMEOUT_EN.
module stage_sequencer import stage_seq_pkg::*; #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Run,
  input  logic               Stall,
  input  logic               Fetch_Ready,
  input  logic               Mem_Access,
  input  logic               Mem_Write,
  input  logic               Mem_Ready,
  input  logic               Wb_Enable,
  input  logic               Halt_Req,
  output logic [STAGE_W-1:0] Stage,
  output logic               ROM1_Read,
  output logic               IR_Enable,
  output logic               PC_Enable,
  output logic               RA_Enable,
  output logic               RB_Enable,
  output logic               RZ_Enable,
  output logic               RM_Enable,
  output logic               Mem_Req,
  output logic               MEM_Read_H_Write_L,
  output logic               RY_Enable,
  output logic               RF_WRITE,
  output logic               Halted,
  output logic [CNT_W-1:0]   Instr_Count,
  output logic               Timeout_Fault
);

  stage_e           state;
  stage_e           state_next;
  logic [CNT_W-1:0] instr_count;
  logic             retire;
  logic             timeout_hit;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (retire) begin
        instr_count <= instr_count + 1'b1;
      end
    end
  end

  // Reset suppresses every decoded output so an abandoned instruction fires nothing
  always_comb begin
    state_next         = state;
    ROM1_Read          = 1'b0;
    IR_Enable          = 1'b0;
    PC_Enable          = 1'b0;
    RA_Enable          = 1'b0;
    RB_Enable          = 1'b0;
    RZ_Enable          = 1'b0;
    RM_Enable          = 1'b0;
    Mem_Req            = 1'b0;
    MEM_Read_H_Write_L = 1'b1;
    RY_Enable          = 1'b0;
    RF_WRITE           = 1'b0;
    Halted             = 1'b0;
    retire             = 1'b0;
    if (!Reset) begin
      case (state)
        IDLE: begin
          if (Run) state_next = FETCH;
        end
        FETCH: begin
          ROM1_Read = 1'b1;
          if (Fetch_Ready) begin
            IR_Enable  = 1'b1;
            PC_Enable  = 1'b1;
            state_next = DECODE;
          end else if (timeout_hit) begin
            state_next = HALT;
          end
        end
        DECODE: begin
          if (!Stall) begin
            if (Halt_Req) begin
              state_next = HALT;
            end else begin
              RA_Enable  = 1'b1;
              RB_Enable  = 1'b1;
              state_next = EXECUTE;
            end
          end
        end
        EXECUTE: begin
          if (!Stall) begin
            RZ_Enable  = 1'b1;
            RM_Enable  = 1'b1;
            state_next = MEMORY;
          end
        end
        MEMORY: begin
          if (Mem_Access) begin
            Mem_Req            = 1'b1;
            MEM_Read_H_Write_L = ~Mem_Write;
            if (Mem_Ready) begin
              RY_Enable  = 1'b1;
              state_next = WRITEBACK;
            end else if (timeout_hit) begin
              state_next = HALT;
            end
          end else begin
            RY_Enable  = 1'b1;
            state_next = WRITEBACK;
          end
        end
        WRITEBACK: begin
          if (!Stall) begin
            RF_WRITE   = Wb_Enable;
            retire     = 1'b1;
            state_next = Run ? FETCH : IDLE;
          end
        end
        HALT: begin
          Halted = 1'b1;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int              WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

  logic wait_active;
  logic wait_ready;
  logic wait_expired;
  logic fault_q;

  assign wait_active = (state == FETCH) || ((state == MEMORY) && Mem_Access);
  assign wait_ready  = (state == FETCH) ? Fetch_Ready : Mem_Ready;
  assign timeout_hit = wait_expired;

  // Any cycle outside a wait state clears the counter, so each FETCH/MEMORY visit starts at zero
  stage_wait_timer #(
    .W(WAIT_W)
  ) u_wait_timer (
    .clk    (Clock),
    .rst    (Reset),
    .clear  (!wait_active),
    .count  (wait_active && !wait_ready),
    .limit  (WAIT_LIMIT),
    .expired(wait_expired)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      fault_q <= 1'b0;
    end else if (wait_active && !wait_ready && wait_expired) begin
      fault_q <= 1'b1;
    end
  end

  assign Timeout_Fault = fault_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign Timeout_Fault      = 1'b0;
`endif

  assign Stage       = state;
  assign Instr_Count = instr_count;

endmodule
